// File: rtl/ofs_plat_hssi_tx_pkt_arbiter.sv
// Packet-level round-robin arbiter sharing one HSSI TX AXI-S channel among NUM_SRC requesters.
// A granted packet runs to its tlast handshake; pause_req only blocks new grants.
//
// state | meaning
// IDLE  | no packet in flight; arbitrate (unless paused) and register winner
// BUSY  | granted source's beats muxed straight to m_* until tlast handshake
module ofs_plat_hssi_tx_pkt_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 1,
  parameter int CNT_WIDTH  = 16,
  localparam int GW        = $clog2(NUM_SRC),
  localparam int KW        = DATA_WIDTH / 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_SRC-1:0]              src_tvalid,
  output logic [NUM_SRC-1:0]              src_tready,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]   src_tdata,
  input  logic [NUM_SRC*KW-1:0]           src_tkeep,
  input  logic [NUM_SRC-1:0]              src_tlast,
  input  logic [NUM_SRC*USER_WIDTH-1:0]   src_tuser,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  output logic [DATA_WIDTH-1:0]           m_tdata,
  output logic [KW-1:0]                   m_tkeep,
  output logic                            m_tlast,
  output logic [USER_WIDTH-1:0]           m_tuser,
  input  logic                            pause_req,
  output logic                            busy,
  output logic [GW-1:0]                   grant_idx,
  output logic [NUM_SRC*CNT_WIDTH-1:0]    pkt_cnt
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]           state;
  logic [GW-1:0]        last_grant;
  logic [CNT_WIDTH-1:0] cnt_q [NUM_SRC];
  logic                 win_found;
  logic [GW-1:0]        win_idx;
  logic [GW:0]          rr_sum;
  logic                 in_busy;
  logic                 pkt_done;

  assign in_busy  = (state == BUSY);
  assign busy     = in_busy;
  assign pkt_done = in_busy & m_tvalid & m_tready & m_tlast;

  // Walk candidates starting one past the last grant; one spare bit absorbs the wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    rr_sum    = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      rr_sum = {1'b0, last_grant} + (GW+1)'(i);
      if (rr_sum >= (GW+1)'(NUM_SRC))
        rr_sum = rr_sum - (GW+1)'(NUM_SRC);
      if (!win_found && src_tvalid[rr_sum[GW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = rr_sum[GW-1:0];
      end
    end
  end

  // m_tvalid depends only on state, grant and src_tvalid, never on m_tready.
  always_comb begin
    m_tvalid   = 1'b0;
    m_tdata    = '0;
    m_tkeep    = '0;
    m_tlast    = 1'b0;
    m_tuser    = '0;
    src_tready = '0;
    if (in_busy) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (grant_idx == GW'(i)) begin
          m_tvalid      = src_tvalid[i];
          m_tdata       = src_tdata[i*DATA_WIDTH +: DATA_WIDTH];
          m_tkeep       = src_tkeep[i*KW +: KW];
          m_tlast       = src_tlast[i];
          m_tuser       = src_tuser[i*USER_WIDTH +: USER_WIDTH];
          src_tready[i] = m_tready;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant_idx  <= '0;
      last_grant <= GW'(NUM_SRC - 1);
    end else if (state == IDLE) begin
      if (!pause_req && win_found) begin
        grant_idx  <= win_idx;
        last_grant <= win_idx;
        state      <= BUSY;
      end
    end else if (pkt_done) begin
      state <= IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SRC; i++)
        cnt_q[i] <= '0;
    end else if (pkt_done) begin
      for (int i = 0; i < NUM_SRC; i++)
        if (grant_idx == GW'(i))
          cnt_q[i] <= cnt_q[i] + 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_cnt
    assign pkt_cnt[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_q[gi];
  end

endmodule

// File: tb/tb_ofs_plat_hssi_tx_pkt_arbiter.sv
// Directed bench for the HSSI TX packet arbiter; per-source packet drivers and hand-built cycle tables.
module tb_ofs_plat_hssi_tx_pkt_arbiter;
  localparam int NS = 4;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int UW = 1;
  localparam int CW = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NS-1:0]    src_tvalid, src_tready, src_tlast;
  logic [NS*DW-1:0] src_tdata;
  logic [NS*KW-1:0] src_tkeep;
  logic [NS*UW-1:0] src_tuser;
  logic             m_tvalid, m_tready, m_tlast;
  logic [DW-1:0]    m_tdata;
  logic [KW-1:0]    m_tkeep;
  logic [UW-1:0]    m_tuser;
  logic             pause_req, busy;
  logic [1:0]       grant_idx;
  logic [NS*CW-1:0] pkt_cnt;

  int passes = 0;
  int checks = 0;
  int len [NS], npkt [NS], beat [NS], pcnt [NS];
  logic bub [NS];
  logic rdy_v;

  always #5 clk = ~clk;

  ofs_plat_hssi_tx_pkt_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .USER_WIDTH(UW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_tvalid(src_tvalid), .src_tready(src_tready), .src_tdata(src_tdata),
    .src_tkeep(src_tkeep), .src_tlast(src_tlast), .src_tuser(src_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_tlast(m_tlast), .m_tuser(m_tuser),
    .pause_req(pause_req), .busy(busy), .grant_idx(grant_idx), .pkt_cnt(pkt_cnt)
  );

  function automatic logic [63:0] dat(int s, int p, int b);
    return (64'(s) << 32) | (64'(p) << 16) | 64'(b);
  endfunction

  function automatic logic [CW-1:0] cnt(int s);
    return pkt_cnt[s*CW +: CW];
  endfunction

  task automatic drive();
    for (int s = 0; s < NS; s++) begin
      src_tvalid[s]           = (npkt[s] > 0) && !bub[s];
      src_tdata[s*DW +: DW]   = dat(s, pcnt[s], beat[s]);
      src_tkeep[s*KW +: KW]   = 8'hFF >> s;
      src_tlast[s]            = (beat[s] == len[s] - 1);
      src_tuser[s]            = 1'(beat[s] & 1);
    end
    m_tready = rdy_v;
  endtask

  task automatic clear_src();
    for (int s = 0; s < NS; s++) begin
      len[s] = 1; npkt[s] = 0; beat[s] = 0; pcnt[s] = 0; bub[s] = 1'b0;
    end
    rdy_v = 1'b1;
  endtask

  // Advance one clock: sources that handshook move to their next beat.
  task automatic step();
    logic [NS-1:0] hs;
    hs = src_tvalid & src_tready;
    @(posedge clk); #1;
    for (int s = 0; s < NS; s++) begin
      if (hs[s]) begin
        if (beat[s] == len[s] - 1) begin
          beat[s] = 0; npkt[s]--; pcnt[s]++;
        end else begin
          beat[s]++;
        end
      end
    end
    drive();
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    pause_req = 1'b0;
    clear_src();
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pause_req = 1'b0;
    clear_src();
    npkt[0] = 1; len[0] = 2;
    drive();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({m_tvalid, busy} !== 2'b00 || src_tready !== 4'b0)
      $display("FAIL reset_outputs got m_tvalid=%b busy=%b src_tready=%b exp 0/0/0000", m_tvalid, busy, src_tready);
    else passes++;
    checks++;
    if (grant_idx !== 2'd0 || pkt_cnt !== 16'h0)
      $display("FAIL reset_regs got grant_idx=%0d pkt_cnt=%h exp 0/0000", grant_idx, pkt_cnt);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || m_tvalid !== 1'b0 || m_tdata !== 64'h0)
      $display("FAIL reset_release_idle got busy=%b m_tvalid=%b m_tdata=%h exp 0/0/0", busy, m_tvalid, m_tdata);
    else passes++;
  endtask

  task automatic test_two_src();
    int es [9] = '{-1, 0, 0, 0, -1, 2, 2, 2, -1};
    int eb [9] = '{0, 0, 1, 2, 0, 0, 1, 2, 0};
    reset_dut();
    len[0] = 3; npkt[0] = 1; len[2] = 3; npkt[2] = 1;
    drive(); #1;
    for (int c = 0; c < 9; c++) begin
      checks++;
      if (es[c] < 0) begin
        if ({m_tvalid, busy} !== 2'b00 || src_tready !== 4'b0 || m_tdata !== 64'h0)
          $display("FAIL two_src_idle c=%0d got m_tvalid=%b busy=%b src_tready=%b m_tdata=%h exp idle", c, m_tvalid, busy, src_tready, m_tdata);
        else passes++;
      end else begin
        if (busy !== 1'b1 || m_tvalid !== 1'b1 || grant_idx !== 2'(es[c]) ||
            m_tdata !== dat(es[c], 0, eb[c]) || m_tkeep !== (8'hFF >> es[c]) ||
            m_tlast !== (eb[c] == 2) || m_tuser !== 1'(eb[c] & 1))
          $display("FAIL two_src_beat c=%0d got grant=%0d m_tvalid=%b m_tdata=%h m_tkeep=%h m_tlast=%b exp grant=%0d m_tdata=%h",
                   c, grant_idx, m_tvalid, m_tdata, m_tkeep, m_tlast, es[c], dat(es[c], 0, eb[c]));
        else passes++;
      end
      if (c < 8) step();
    end
    checks++;
    if (cnt(0) !== 4'd1 || cnt(1) !== 4'd0 || cnt(2) !== 4'd1)
      $display("FAIL two_src_cnt got pkt_cnt=%h exp 0100 in slots 2..0 as 1,0,1", pkt_cnt);
    else passes++;
  endtask

  task automatic test_round_robin();
    reset_dut();
    for (int s = 0; s < NS; s++) begin
      len[s] = 2; npkt[s] = 2;
    end
    drive(); #1;
    for (int c = 0; c <= 24; c++) begin
      int k = c / 3;
      int ph = c % 3;
      checks++;
      if (ph == 0) begin
        if ({m_tvalid, busy} !== 2'b00)
          $display("FAIL rr_gap c=%0d got m_tvalid=%b busy=%b exp 0/0", c, m_tvalid, busy);
        else passes++;
      end else begin
        if (busy !== 1'b1 || m_tvalid !== 1'b1 || grant_idx !== 2'(k % 4) ||
            m_tdata !== dat(k % 4, k / 4, ph - 1) || m_tlast !== (ph == 2) ||
            src_tready !== (4'b1 << (k % 4)))
          $display("FAIL rr_beat c=%0d got grant=%0d m_tdata=%h src_tready=%b exp grant=%0d m_tdata=%h",
                   c, grant_idx, m_tdata, src_tready, k % 4, dat(k % 4, k / 4, ph - 1));
        else passes++;
      end
      if (c < 24) step();
    end
    checks++;
    if (pkt_cnt !== 16'h2222)
      $display("FAIL rr_cnt got pkt_cnt=%h exp 2222", pkt_cnt);
    else passes++;
  endtask

  task automatic test_pause();
    int es [11] = '{-1, 1, 1, 1, 1, 1, -1, -1, -1, 2, -1};
    int eb [11] = '{0, 0, 1, 2, 3, 4, 0, 0, 0, 0, 0};
    reset_dut();
    len[1] = 5; npkt[1] = 1; len[2] = 1; npkt[2] = 1;
    drive(); #1;
    for (int c = 0; c < 11; c++) begin
      checks++;
      if (es[c] < 0) begin
        if ({m_tvalid, busy} !== 2'b00 || src_tready !== 4'b0)
          $display("FAIL pause_idle c=%0d got m_tvalid=%b busy=%b src_tready=%b exp idle", c, m_tvalid, busy, src_tready);
        else passes++;
      end else begin
        if (busy !== 1'b1 || m_tvalid !== 1'b1 || grant_idx !== 2'(es[c]) ||
            m_tdata !== dat(es[c], 0, eb[c]) || m_tlast !== (c == 5 || c == 9))
          $display("FAIL pause_beat c=%0d got grant=%0d m_tvalid=%b m_tdata=%h m_tlast=%b exp grant=%0d m_tdata=%h",
                   c, grant_idx, m_tvalid, m_tdata, m_tlast, es[c], dat(es[c], 0, eb[c]));
        else passes++;
      end
      if (c == 3) pause_req = 1'b1;
      if (c == 8) pause_req = 1'b0;
      if (c < 10) step();
    end
    checks++;
    if (cnt(1) !== 4'd1 || cnt(2) !== 4'd1)
      $display("FAIL pause_cnt got pkt_cnt=%h exp src1=1 src2=1", pkt_cnt);
    else passes++;
  endtask

  task automatic test_ready_bubble();
    logic rdy [12] = '{1, 1, 0, 1, 0, 1, 0, 1, 1, 1, 1, 1};
    int es  [12] = '{-1, 1, 1, 1, 1, 1, 1, 1, 1, -1, 3, -1};
    logic ev [12] = '{0, 1, 1, 0, 1, 1, 1, 1, 1, 0, 1, 0};
    int eb  [12] = '{0, 0, 1, 0, 1, 1, 2, 2, 3, 0, 0, 0};
    logic [3:0] etr [12] = '{4'h0, 4'h2, 4'h0, 4'h2, 4'h0, 4'h2, 4'h0, 4'h2, 4'h2, 4'h0, 4'h8, 4'h0};
    int nxt = 0;
    reset_dut();
    len[1] = 4; npkt[1] = 1; len[3] = 1; npkt[3] = 1;
    drive(); #1;
    for (int c = 0; c < 12; c++) begin
      checks++;
      if (es[c] < 0) begin
        if ({m_tvalid, busy} !== 2'b00 || src_tready !== 4'b0)
          $display("FAIL rdy_idle c=%0d got m_tvalid=%b busy=%b src_tready=%b exp idle", c, m_tvalid, busy, src_tready);
        else passes++;
      end else begin
        if (busy !== 1'b1 || grant_idx !== 2'(es[c]) || m_tvalid !== ev[c] || src_tready !== etr[c] ||
            (ev[c] && m_tdata !== dat(es[c], 0, eb[c])))
          $display("FAIL rdy_beat c=%0d got grant=%0d m_tvalid=%b src_tready=%b m_tdata=%h exp grant=%0d m_tvalid=%b src_tready=%b m_tdata=%h",
                   c, grant_idx, m_tvalid, src_tready, m_tdata, es[c], ev[c], etr[c], dat(es[c], 0, eb[c]));
        else passes++;
      end
      if (m_tvalid === 1'b1 && m_tready === 1'b1 && grant_idx === 2'd1) begin
        checks++;
        if (m_tdata !== dat(1, 0, nxt))
          $display("FAIL rdy_order got m_tdata=%h exp %h", m_tdata, dat(1, 0, nxt));
        else passes++;
        nxt++;
      end
      if (c < 11) begin
        rdy_v = rdy[c+1];
        bub[1] = (c + 1 == 3);
        step();
      end
    end
    checks++;
    if (nxt !== 4 || cnt(1) !== 4'd1 || cnt(3) !== 4'd1)
      $display("FAIL rdy_total got beats=%0d pkt_cnt=%h exp beats=4 src1=1 src3=1", nxt, pkt_cnt);
    else passes++;
  endtask

  task automatic test_async_reset();
    clear_src();
    len[3] = 5; npkt[3] = 1;
    drive(); #1;
    for (int c = 0; c < 3; c++) step();
    checks++;
    if (busy !== 1'b1 || grant_idx !== 2'd3 || m_tdata !== dat(3, 0, 2) || cnt(1) !== 4'd1)
      $display("FAIL arst_pre got busy=%b grant=%0d m_tdata=%h pkt_cnt=%h exp 1/3/%h src1=1", busy, grant_idx, m_tdata, pkt_cnt, dat(3, 0, 2));
    else passes++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({m_tvalid, busy} !== 2'b00 || src_tready !== 4'b0 || pkt_cnt !== 16'h0 || grant_idx !== 2'd0)
      $display("FAIL arst_immediate got m_tvalid=%b busy=%b src_tready=%b pkt_cnt=%h grant=%0d exp all 0",
               m_tvalid, busy, src_tready, pkt_cnt, grant_idx);
    else passes++;
    clear_src();
    len[3] = 5; npkt[3] = 1; len[0] = 1; npkt[0] = 1;
    drive();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || m_tvalid !== 1'b0)
      $display("FAIL arst_release got busy=%b m_tvalid=%b exp 0/0", busy, m_tvalid);
    else passes++;
    step();
    checks++;
    if (busy !== 1'b1 || grant_idx !== 2'd0 || m_tdata !== dat(0, 0, 0))
      $display("FAIL arst_prio got grant=%0d busy=%b m_tdata=%h exp grant=0 m_tdata=%h", grant_idx, busy, m_tdata, dat(0, 0, 0));
    else passes++;
    step();
    step();
    checks++;
    if (busy !== 1'b1 || grant_idx !== 2'd3 || m_tdata !== dat(3, 0, 0) || cnt(0) !== 4'd1)
      $display("FAIL arst_restart got grant=%0d m_tdata=%h pkt_cnt=%h exp grant=3 m_tdata=%h src0=1", grant_idx, m_tdata, pkt_cnt, dat(3, 0, 0));
    else passes++;
  endtask

  task automatic test_cnt_wrap();
    reset_dut();
    len[0] = 1; npkt[0] = 17;
    drive(); #1;
    for (int c = 0; c <= 34; c++) begin
      checks++;
      if (c % 2 == 1) begin
        if (busy !== 1'b1 || m_tvalid !== 1'b1 || grant_idx !== 2'd0 || m_tlast !== 1'b1 || m_tdata !== dat(0, c / 2, 0))
          $display("FAIL wrap_beat c=%0d got busy=%b m_tvalid=%b m_tdata=%h exp 1/1/%h", c, busy, m_tvalid, m_tdata, dat(0, c / 2, 0));
        else passes++;
      end else begin
        if ({m_tvalid, busy} !== 2'b00)
          $display("FAIL wrap_gap c=%0d got m_tvalid=%b busy=%b exp 0/0", c, m_tvalid, busy);
        else passes++;
      end
      if (c == 32) begin
        checks++;
        if (cnt(0) !== 4'd0)
          $display("FAIL wrap_cnt16 got %0d exp 0", cnt(0));
        else passes++;
      end
      if (c < 34) step();
    end
    checks++;
    if (cnt(0) !== 4'd1 || pkt_cnt[15:4] !== 12'h0)
      $display("FAIL wrap_cnt17 got pkt_cnt=%h exp 0001", pkt_cnt);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_two_src();
    test_round_robin();
    test_pause();
    test_ready_bubble();
    test_async_reset();
    test_cnt_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end

endmodule

// File: doc/ofs_plat_hssi_tx_pkt_arbiter.md
# ofs_plat_hssi_tx_pkt_arbiter

Packet-level round-robin arbiter sharing one HSSI channel's TX AXI-S data stream among NUM_SRC AFU requesters. Sits between per-requester TX streams and a single channel's `data_tx` port. Once granted, a packet is carried to completion (`tlast`) without interleaving. A sideband pause request holds off new grants at packet boundaries. Provides per-source completed-packet counters for debug.

## Interface
Parameters:
- NUM_SRC, 4, number of requesters (2..16)
- DATA_WIDTH, 64, tdata width in bits (multiple of 8); tkeep width = DATA_WIDTH/8
- USER_WIDTH, 1, tuser width
- CNT_WIDTH, 16, per-source packet counter width

Ports:
- clk  in  1  channel TX clock
- rst_n  in  1  asynchronous active-low reset
- src_tvalid  in  NUM_SRC  per-source beat valid
- src_tready  out  NUM_SRC  per-source ready
- src_tdata  in  NUM_SRC*DATA_WIDTH  source i in slice [i*DATA_WIDTH +: DATA_WIDTH]
- src_tkeep  in  NUM_SRC*DATA_WIDTH/8  per-source byte enables
- src_tlast  in  NUM_SRC  per-source end of packet
- src_tuser  in  NUM_SRC*USER_WIDTH  per-source user bits
- m_tvalid  out  1  channel beat valid
- m_tready  in  1  channel ready
- m_tdata / m_tkeep / m_tlast / m_tuser  out  DATA_WIDTH / DATA_WIDTH/8 / 1 / USER_WIDTH  channel payload
- pause_req  in  1  sideband pause; blocks new grants
- busy  out  1  a packet is granted and in flight
- grant_idx  out  $clog2(NUM_SRC)  currently/last granted source
- pkt_cnt  out  NUM_SRC*CNT_WIDTH  completed packets per source

## Operation
- State machine with two states: IDLE and BUSY.
- IDLE:
  - m_tvalid=0; all src_tready=0.
  - If pause_req=0 and any src_tvalid=1, select the winner by round-robin. Priority starts at (last_grant+1) mod NUM_SRC and wraps past NUM_SRC-1 to 0.
  - Register the winner into grant_idx and last_grant, then go to BUSY.
  - If pause_req=1, stay in IDLE regardless of src_tvalid.
- BUSY:
  - m_tvalid=src_tvalid[g]; m_tdata/tkeep/tlast/tuser come from slice g.
  - src_tready[g]=m_tready; all other src_tready=0.
  - On a handshake (m_tvalid & m_tready) with m_tlast=1: increment pkt_cnt[g], which wraps modulo 2^CNT_WIDTH. Then return to IDLE.
  - src_tvalid[g] dropping mid-packet is a legal bubble: m_tvalid=0 and the grant is held.
- pause_req asserting during BUSY has no effect until the current packet's tlast handshake. The arbiter then stays in IDLE until pause_req=0.
- A single-beat packet (tvalid and tlast in the same beat) is legal. It completes in one BUSY cycle.
- busy=1 exactly in BUSY.
- Payload outputs in IDLE are don't-care. The implementation drives them to 0.
- Reset values, including async assertion mid-packet:
  - state=IDLE, m_tvalid=0, src_tready=0, busy=0.
  - grant_idx=0; last_grant=NUM_SRC-1, so source 0 has top priority after reset.
  - pkt_cnt all 0.
  - A packet truncated by reset is not resumed or counted.

## Timing
- Arbitration latency: one IDLE cycle. A source asserting tvalid in cycle n (arbiter idle, no pause) sees its first beat on m_* in cycle n+1.
- Inter-packet gap: one IDLE cycle after every tlast handshake. Max throughput is L/(L+1) for L-beat packets.
- Data path is combinational from src_* through the grant mux to m_*.
- src_tready[g] is combinational from m_tready.
- There is no combinational path from m_tready to m_tvalid.
- pkt_cnt updates the cycle after the tlast handshake.
- pause_req is sampled only in IDLE, synchronously to clk.

## Test plan
- Post-reset, src 0 and src 2 both present 3-beat packets → src 0's three beats appear in cycles 1–3, an IDLE cycle follows, then src 2's packet; pkt_cnt[0]=1, pkt_cnt[2]=1.
- All four sources continuously valid with 2-beat packets → grant_idx sequence 0,1,2,3,0 with wrap-around; no beat interleaving; each pkt_cnt=2 after 8 packets.
- pause_req rises on beat 2 of a 5-beat packet from src 1 → all 5 beats delivered. IDLE holds with m_tvalid=0 while pause_req=1. The next grant goes to src 2 one cycle after pause_req falls.
- m_tready toggles 1,0,1,0 and src_tvalid[g] has a mid-packet bubble → every beat transferred exactly once in order; non-granted src_tready stay 0.
- rst_n asserted asynchronously on beat 3 of src 3's packet → m_tvalid and busy go 0 immediately, pkt_cnt all 0. After release, src 0 wins over src 3 when both are valid.
- CNT_WIDTH=4, src 0 sends 17 single-beat packets → pkt_cnt[0] reads 1 (wrapped), with each packet occupying 2 cycles.
